// File: rtl/counter_sequencer.sv
// Command sequencer for the SmartCounter: queues {start,len} commands, drives
// load/enable/load_val and reports the sampled count with a done pulse.
module counter_sequencer #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_start,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             abort,
   output logic             cnt_load,
   output logic             cnt_enable,
   output logic [WIDTH-1:0] cnt_load_val,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] done_q
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} state_t;

   state_t           state;
   logic [WIDTH-1:0] fifo_start [DEPTH];
   logic [LEN_W-1:0] fifo_len   [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic [LEN_W-1:0] rem;
   logic             push;
   logic             pop;

   // Room is judged on the registered count only, so a pop never frees a slot
   // for a push in the same cycle.
   assign cmd_ready = (count < FULL_CNT) && !rst;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == IDLE) && (count != '0);
   assign busy      = (state != IDLE) || (count != '0);

   // Command storage carries no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_start[wr_ptr] <= cmd_start;
         fifo_len[wr_ptr]   <= cmd_len;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // rem holds the enables still to issue, counting down to the last RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt_load     <= 1'b0;
         cnt_enable   <= 1'b0;
         cnt_load_val <= '0;
         done         <= 1'b0;
         done_q       <= '0;
         rem          <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               cnt_load   <= 1'b0;
               cnt_enable <= 1'b0;
               if (pop) begin
                  cnt_load     <= 1'b1;
                  cnt_load_val <= fifo_start[rd_ptr];
                  rem          <= fifo_len[rd_ptr];
                  state        <= LOAD;
               end
            end
            LOAD: begin
               cnt_load <= 1'b0;
               if (abort || (rem == '0)) begin
                  cnt_enable <= 1'b0;
                  state      <= FINISH;
               end else begin
                  cnt_enable <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               if (abort || (rem == LEN_W'(1))) begin
                  cnt_enable <= 1'b0;
                  state      <= FINISH;
               end else begin
                  rem <= rem - 1'b1;
               end
            end
            FINISH: begin
               cnt_load   <= 1'b0;
               cnt_enable <= 1'b0;
               done       <= 1'b1;
               done_q     <= cnt_q;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural SmartCounter attached
// to the cnt_* port, checked cycle by cycle against hand-computed timelines.
module tb_counter_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_start = 8'h00;
   logic [7:0] cmd_len = 8'h00;
   logic       abort = 1'b0;
   logic       cnt_load;
   logic       cnt_enable;
   logic [7:0] cnt_load_val;
   logic [7:0] cnt_q;
   logic       busy;
   logic       done;
   logic [7:0] done_q;
   logic       cnt_rst_n = 1'b0;

   int tests = 0;
   int fails = 0;
   int cycle = 0;
   logic [7:0] done_log [$];

   counter_sequencer #(.WIDTH(8), .LEN_W(8), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_start(cmd_start), .cmd_len(cmd_len), .abort(abort),
      .cnt_load(cnt_load), .cnt_enable(cnt_enable), .cnt_load_val(cnt_load_val),
      .cnt_q(cnt_q), .busy(busy), .done(done), .done_q(done_q)
   );

   always #5 clk = ~clk;

   // SmartCounter: async reset, load has priority over enable, wraps mod 256.
   always @(posedge clk or negedge cnt_rst_n) begin
      if (!cnt_rst_n)
         cnt_q <= 8'h00;
      else if (cnt_load)
         cnt_q <= cnt_load_val;
      else if (cnt_enable)
         cnt_q <= cnt_q + 8'h01;
   end

   always @(negedge clk)
      if (done)
         done_log.push_back(done_q);

   task automatic step();
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Push one command from an idle, empty sequencer and follow its full timeline.
   task automatic run_cmd(input string tag, input logic [7:0] st, input logic [7:0] ln,
                          input logic [7:0] exp_q);
      int ens;
      int last;
      ens  = 0;
      last = 4 + int'(ln);
      cmd_valid = 1'b1;
      cmd_start = st;
      cmd_len   = ln;
      chk($sformatf("%s ready", tag), 32'(cmd_ready), 32'd1);
      for (int c = 1; c <= last; c++) begin
         step();
         cmd_valid = 1'b0;
         chk($sformatf("%s load c%0d", tag, c), 32'(cnt_load), 32'(c == 2));
         chk($sformatf("%s done c%0d", tag, c), 32'(done), 32'(c == last));
         if (c == 2)
            chk($sformatf("%s load_val", tag), 32'(cnt_load_val), 32'(st));
         if (cnt_enable)
            ens++;
      end
      chk($sformatf("%s enables", tag), 32'(ens), 32'(ln));
      chk($sformatf("%s done_q", tag), 32'(done_q), 32'(exp_q));
      step();
      chk($sformatf("%s done low", tag), 32'(done), 32'd0);
      chk($sformatf("%s done_q held", tag), 32'(done_q), 32'(exp_q));
      chk($sformatf("%s idle", tag), 32'(busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int idx;
      int c;
      int last_push;
      logic acc;

      // Reset, with a push attempted while rst is high.
      cmd_valid = 1'b1;
      cmd_start = 8'h77;
      cmd_len   = 8'h02;
      step();
      cnt_rst_n = 1'b1;
      step();
      chk("rst ready", 32'(cmd_ready), 32'd0);
      chk("rst load", 32'(cnt_load), 32'd0);
      chk("rst enable", 32'(cnt_enable), 32'd0);
      chk("rst load_val", 32'(cnt_load_val), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst done_q", 32'(done_q), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      cmd_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("post rst ready", 32'(cmd_ready), 32'd1);
      step();
      chk("post rst busy", 32'(busy), 32'd0);

      run_cmd("basic", 8'h3C, 8'd5, 8'h41);
      run_cmd("len0", 8'hAA, 8'd0, 8'hAA);
      run_cmd("wrap", 8'hFE, 8'd5, 8'h03);

      // Six back-to-back commands, len=10, starts 00,10,..,50.
      done_log.delete();
      idx = 0;
      c = 0;
      last_push = -1;
      cmd_valid = 1'b1;
      cmd_len   = 8'd10;
      while (idx < 6 && c < 40) begin
         cmd_start = 8'(idx * 16);
         if (c <= 4)
            chk($sformatf("fill ready c%0d", c), 32'(cmd_ready), 32'd1);
         else if (c <= 14)
            chk($sformatf("fill full c%0d", c), 32'(cmd_ready), 32'd0);
         acc = cmd_ready;
         if (acc)
            last_push = c;
         step();
         c++;
         if (acc)
            idx++;
      end
      cmd_valid = 1'b0;
      chk("fill accepted", 32'(idx), 32'd6);
      chk("fill 6th push cycle", 32'(last_push), 32'd15);
      for (int i = 0; i < 200 && done_log.size() < 6; i++)
         step();
      chk("b2b done count", 32'(done_log.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("b2b done_q %0d", i), 32'(done_log[i]), 32'(8'(i * 16 + 10)));
      step();
      chk("b2b idle", 32'(busy), 32'd0);

      // Abort in the third RUN cycle, with a second command queued behind it.
      done_log.delete();
      cmd_valid = 1'b1;
      cmd_start = 8'h10;
      cmd_len   = 8'd20;
      step();
      cmd_start = 8'h80;
      cmd_len   = 8'd2;
      step();
      cmd_valid = 1'b0;
      chk("abort load", 32'(cnt_load), 32'd1);
      chk("abort load_val", 32'(cnt_load_val), 32'h10);
      step();
      chk("abort run1", 32'(cnt_enable), 32'd1);
      step();
      chk("abort run2", 32'(cnt_enable), 32'd1);
      step();
      chk("abort run3", 32'(cnt_enable), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort finish enable", 32'(cnt_enable), 32'd0);
      chk("abort finish done", 32'(done), 32'd0);
      step();
      chk("abort done", 32'(done), 32'd1);
      chk("abort done_q", 32'(done_q), 32'h13);
      step();
      chk("next load", 32'(cnt_load), 32'd1);
      chk("next load_val", 32'(cnt_load_val), 32'h80);
      step();
      chk("next run1", 32'(cnt_enable), 32'd1);
      step();
      chk("next run2", 32'(cnt_enable), 32'd1);
      step();
      chk("next finish", 32'(cnt_enable), 32'd0);
      step();
      chk("next done", 32'(done), 32'd1);
      chk("next done_q", 32'(done_q), 32'h82);
      step();
      chk("abort done count", 32'(done_log.size()), 32'd2);

      // Reset mid-RUN with two commands queued; a push during reset is dropped.
      done_log.delete();
      cmd_valid = 1'b1;
      cmd_start = 8'h20;
      cmd_len   = 8'd10;
      step();
      cmd_start = 8'h30;
      cmd_len   = 8'd1;
      step();
      cmd_start = 8'h40;
      step();
      cmd_valid = 1'b0;
      step();
      step();
      chk("mid run enable", 32'(cnt_enable), 32'd1);
      rst = 1'b1;
      cmd_valid = 1'b1;
      cmd_start = 8'h99;
      #1;
      chk("mid rst ready", 32'(cmd_ready), 32'd0);
      step();
      rst = 1'b0;
      cmd_valid = 1'b0;
      chk("mid rst load", 32'(cnt_load), 32'd0);
      chk("mid rst enable", 32'(cnt_enable), 32'd0);
      chk("mid rst load_val", 32'(cnt_load_val), 32'd0);
      chk("mid rst done", 32'(done), 32'd0);
      chk("mid rst done_q", 32'(done_q), 32'd0);
      chk("mid rst busy", 32'(busy), 32'd0);
      for (int i = 0; i < 20; i++)
         step();
      chk("mid rst no done", 32'(done_log.size()), 32'd0);
      chk("mid rst still idle", 32'(busy), 32'd0);
      run_cmd("post rst", 8'h55, 8'd3, 8'h58);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
